// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Definitions shared by the UART transmitter and receiver:
//                frame state encodings, parity-mode constants and the
//                default baud divider.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Frame sequencer states. Width is fixed so the encodings are identical
    // across every block that imports this package.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    // Seed XORed into the data parity: 0 gives even parity, 1 gives odd parity.
    localparam logic c_PARITY_EVEN = 1'b0;
    localparam logic c_PARITY_ODD  = 1'b1;

    // clk cycles per serial bit when the instantiating block does not override it.
    localparam int c_DEFAULT_CLKS_PER_BIT = 16;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// ============================================================================
//  Module      : uart_baud_tick
//  Description : Baud counter. Counts 0..CLKS_PER_BIT-1 and asserts tick for
//                one cycle on the terminal count. clear holds the count at 0
//                so a bit period starts exactly when the owner releases it.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = c_DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int                 c_CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(CLKS_PER_BIT - 1);

    logic [c_CNT_W-1:0] r_cnt;

    assign tick = (r_cnt == c_LAST);

    // Count one bit period, wrapping to zero on the terminal count only.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_cnt <= '0;
        end else if (tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule : uart_baud_tick
`default_nettype wire

// File: rtl/uart_tx_frame.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_frame
//  Description : Parametrised UART transmitter with valid/ready input.
//                Frame = start bit, DATA_W data bits (LSB first), optional
//                parity bit, STOP_BITS stop bits; each bit CLKS_PER_BIT clks.
//                The serial output is driven straight from a flop.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = c_DEFAULT_CLKS_PER_BIT,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    localparam int                 c_BIT_W       = $clog2(DATA_W + 1);
    localparam logic [c_BIT_W-1:0] c_LAST_DATA   = c_BIT_W'(DATA_W - 1);
    localparam logic [c_BIT_W-1:0] c_LAST_STOP   = c_BIT_W'(STOP_BITS - 1);
    localparam logic               c_PARITY_SEED = (PARITY_ODD != 0) ? c_PARITY_ODD : c_PARITY_EVEN;

    uart_state_e        r_state;
    uart_state_e        w_state_next;
    logic [DATA_W-1:0]  r_shift;
    logic [DATA_W-1:0]  w_shift_next;
    logic [c_BIT_W-1:0] r_bit_cnt;
    logic [c_BIT_W-1:0] w_bit_cnt_next;
    logic               r_parity;
    logic               w_parity_next;
    logic               r_tx;
    logic               w_tx_next;
    logic               w_done;
    logic               w_accept;
    logic               w_tick;

    assign tx_ready = (r_state == ST_IDLE);
    assign busy     = (r_state != ST_IDLE);
    assign w_accept = tx_valid && tx_ready;
    assign tx       = r_tx;
    assign done     = w_done;

    // The baud counter is parked at zero while idle, so the start bit gets a
    // full period beginning on the accept edge.
    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_tick (
        .clk   (clk),
        .rst   (rst),
        .clear (r_state == ST_IDLE),
        .tick  (w_tick)
    );

    // State, shift register, bit counter, parity and serial output flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_parity  <= 1'b0;
            r_tx      <= 1'b1;
        end else begin
            r_state   <= w_state_next;
            r_shift   <= w_shift_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_parity  <= w_parity_next;
            r_tx      <= w_tx_next;
        end
    end

    // Next-state logic; w_tx_next is the line level for the coming bit period.
    always_comb begin
        w_state_next   = r_state;
        w_shift_next   = r_shift;
        w_bit_cnt_next = r_bit_cnt;
        w_parity_next  = r_parity;
        w_tx_next      = r_tx;
        w_done         = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_tx_next = 1'b1;
                if (w_accept) begin
                    w_state_next   = ST_START;
                    w_shift_next   = tx_data;
                    w_parity_next  = (^tx_data) ^ c_PARITY_SEED;
                    w_bit_cnt_next = '0;
                    w_tx_next      = 1'b0;
                end
            end

            ST_START: begin
                if (w_tick) begin
                    w_state_next   = ST_DATA;
                    w_bit_cnt_next = '0;
                    w_tx_next      = r_shift[0];
                end
            end

            ST_DATA: begin
                if (w_tick) begin
                    if (r_bit_cnt == c_LAST_DATA) begin
                        w_bit_cnt_next = '0;
                        if (PARITY_EN != 0) begin
                            w_state_next = ST_PARITY;
                            w_tx_next    = r_parity;
                        end else begin
                            w_state_next = ST_STOP;
                            w_tx_next    = 1'b1;
                        end
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + 1'b1;
                        w_shift_next   = r_shift >> 1;
                        w_tx_next      = r_shift[1];
                    end
                end
            end

            ST_PARITY: begin
                if (w_tick) begin
                    w_state_next   = ST_STOP;
                    w_bit_cnt_next = '0;
                    w_tx_next      = 1'b1;
                end
            end

            ST_STOP: begin
                w_tx_next = 1'b1;
                if (w_tick) begin
                    if (r_bit_cnt == c_LAST_STOP) begin
                        w_done         = 1'b1;
                        w_state_next   = ST_IDLE;
                        w_bit_cnt_next = '0;
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + 1'b1;
                    end
                end
            end

            default: begin
                w_state_next   = ST_IDLE;
                w_bit_cnt_next = '0;
                w_tx_next      = 1'b1;
            end
        endcase
    end

endmodule : uart_tx_frame
`default_nettype wire

// File: tb/tb_uart_tx_frame.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_frame
//  Description : Self-checking bench for uart_tx_frame. Four instances cover
//                the default 8N1 build, 7-bit even/odd parity and two stop
//                bits. Expected per-cycle line states are queued when a byte
//                is offered and popped against the selected instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_frame;

    localparam int c_CPB = 16;

    typedef struct packed {
        logic tx;
        logic done;
        logic ready;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       tb_valid;
    logic [8:0] tb_data;
    int         sel;

    logic [3:0] valid_w;
    logic [3:0] ready_w;
    logic [3:0] tx_w;
    logic [3:0] busy_w;
    logic [3:0] done_w;

    logic obs_tx, obs_ready, obs_busy, obs_done;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    assign valid_w[0] = tb_valid && (sel == 0);
    assign valid_w[1] = tb_valid && (sel == 1);
    assign valid_w[2] = tb_valid && (sel == 2);
    assign valid_w[3] = tb_valid && (sel == 3);

    // Route the selected instance to the observation signals.
    always_comb begin
        obs_tx    = tx_w[sel[1:0]];
        obs_ready = ready_w[sel[1:0]];
        obs_busy  = busy_w[sel[1:0]];
        obs_done  = done_w[sel[1:0]];
    end

    uart_tx_frame u_def (
        .clk(clk), .rst(rst), .tx_data(tb_data[7:0]), .tx_valid(valid_w[0]),
        .tx_ready(ready_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .done(done_w[0])
    );

    uart_tx_frame #(.DATA_W(7), .PARITY_EN(1), .PARITY_ODD(0)) u_par_even (
        .clk(clk), .rst(rst), .tx_data(tb_data[6:0]), .tx_valid(valid_w[1]),
        .tx_ready(ready_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .done(done_w[1])
    );

    uart_tx_frame #(.DATA_W(7), .PARITY_EN(1), .PARITY_ODD(1)) u_par_odd (
        .clk(clk), .rst(rst), .tx_data(tb_data[6:0]), .tx_valid(valid_w[2]),
        .tx_ready(ready_w[2]), .tx(tx_w[2]), .busy(busy_w[2]), .done(done_w[2])
    );

    uart_tx_frame #(.STOP_BITS(2)) u_stop2 (
        .clk(clk), .rst(rst), .tx_data(tb_data[7:0]), .tx_valid(valid_w[3]),
        .tx_ready(ready_w[3]), .tx(tx_w[3]), .busy(busy_w[3]), .done(done_w[3])
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One serial bit: c_CPB cycles at level b, done on its final cycle if last.
    function automatic void push_bit(input logic b, input bit last);
        for (int i = 0; i < c_CPB; i++) begin
            exp_q.push_back('{tx: b, done: (last && i == c_CPB - 1), ready: 1'b0});
        end
    endfunction

    function automatic void push_frame(input logic [8:0] data, input int dw,
                                       input int pen, input int podd, input int stops);
        logic p;
        p = (podd != 0);
        push_bit(1'b0, 1'b0);
        for (int i = 0; i < dw; i++) begin
            push_bit(data[i], 1'b0);
            p = p ^ data[i];
        end
        if (pen != 0) push_bit(p, 1'b0);
        for (int s = 0; s < stops; s++) push_bit(1'b1, s == stops - 1);
    endfunction

    function automatic void push_idle();
        exp_q.push_back('{tx: 1'b1, done: 1'b0, ready: 1'b1});
    endfunction

    // Pop up to max_n expected cycles and compare; tb_valid is kept until
    // keep_until pops, optional noise scrambles the inputs while busy.
    task automatic check_stream(input string tag, input int max_n,
                                input int keep_until, input bit noise);
        exp_t e;
        int   idx;
        int   total;
        idx   = 0;
        total = exp_q.size();
        while (exp_q.size() > 0 && idx < max_n) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_tx !== e.tx) begin
                n_errors++;
                $display("FAIL %s tx cyc=%0d: got %b expected %b", tag, idx + 1, obs_tx, e.tx);
            end
            n_checks++;
            if (obs_done !== e.done) begin
                n_errors++;
                $display("FAIL %s done cyc=%0d: got %b expected %b", tag, idx + 1, obs_done, e.done);
            end
            n_checks++;
            if (obs_ready !== e.ready) begin
                n_errors++;
                $display("FAIL %s tx_ready cyc=%0d: got %b expected %b", tag, idx + 1, obs_ready, e.ready);
            end
            n_checks++;
            if (obs_busy !== !e.ready) begin
                n_errors++;
                $display("FAIL %s busy cyc=%0d: got %b expected %b", tag, idx + 1, obs_busy, !e.ready);
            end
            if (noise && idx < total - 2) begin
                tb_data  = 9'($urandom);
                tb_valid = 1'($urandom_range(0, 1));
            end else if (idx >= keep_until) begin
                tb_valid = 1'b0;
            end
            idx++;
            step();
        end
    endtask

    task automatic check_idle(input string tag);
        n_checks++;
        if (obs_tx !== 1'b1) begin
            n_errors++;
            $display("FAIL %s tx: got %b expected 1", tag, obs_tx);
        end
        n_checks++;
        if (obs_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL %s tx_ready: got %b expected 1", tag, obs_ready);
        end
        n_checks++;
        if (obs_busy !== 1'b0) begin
            n_errors++;
            $display("FAIL %s busy: got %b expected 0", tag, obs_busy);
        end
        n_checks++;
        if (obs_done !== 1'b0) begin
            n_errors++;
            $display("FAIL %s done: got %b expected 0", tag, obs_done);
        end
    endtask

    // Reset held for three cycles with tx_valid high must not start a frame.
    task automatic test_reset();
        sel      = 0;
        rst      = 1'b1;
        tb_valid = 1'b1;
        tb_data  = 9'h0F0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_idle("reset");
        end
        tb_valid = 1'b0;
        rst      = 1'b0;
        step();
        check_idle("reset_release");
    endtask

    task automatic send_one(input int s, input logic [8:0] data, input int dw,
                            input int pen, input int podd, input int stops,
                            input string tag, input bit noise);
        sel      = s;
        tb_data  = data;
        tb_valid = 1'b1;
        step();
        push_frame(data, dw, pen, podd, stops);
        check_stream(tag, 1000, 0, noise);
        check_idle({tag, "_end"});
    endtask

    task automatic test_default_frame();
        send_one(0, 9'h0A5, 8, 0, 0, 1, "default_a5", 1'b0);
        send_one(0, 9'h001, 8, 0, 0, 1, "default_01", 1'b0);
    endtask

    task automatic test_parity();
        send_one(1, 9'h053, 7, 1, 0, 1, "parity_even_53", 1'b0);
        send_one(2, 9'h053, 7, 1, 1, 1, "parity_odd_53", 1'b0);
        send_one(1, 9'h07F, 7, 1, 0, 1, "parity_even_7f", 1'b0);
    endtask

    // Two frames with tx_valid held: exactly one idle cycle between them.
    task automatic test_back_to_back();
        sel      = 3;
        tb_data  = 9'h000;
        tb_valid = 1'b1;
        step();
        tb_data = 9'h0FF;
        push_frame(9'h000, 8, 0, 0, 2);
        push_idle();
        push_frame(9'h0FF, 8, 0, 0, 2);
        check_stream("back_to_back", 1000, (1 + 8 + 2) * c_CPB + 1, 1'b0);
        check_idle("back_to_back_end");
    endtask

    // Reset during data bit 3 drops the frame; the next byte goes out whole.
    task automatic test_reset_mid_frame();
        sel      = 0;
        tb_data  = 9'h0A5;
        tb_valid = 1'b1;
        step();
        push_frame(9'h0A5, 8, 0, 0, 1);
        check_stream("mid_frame_pre", (1 + 3) * c_CPB + 6, 0, 1'b0);
        exp_q.delete();
        rst = 1'b1;
        step();
        check_idle("mid_frame_reset");
        rst      = 1'b0;
        tb_data  = 9'h03C;
        tb_valid = 1'b1;
        step();
        push_frame(9'h03C, 8, 0, 0, 1);
        check_stream("mid_frame_after", 1000, 0, 1'b0);
        check_idle("mid_frame_after_end");
    endtask

    task automatic test_busy_ignore();
        send_one(0, 9'h096, 8, 0, 0, 1, "busy_ignore", 1'b1);
    endtask

    initial begin
        rst      = 1'b1;
        tb_valid = 1'b0;
        tb_data  = '0;
        sel      = 0;
        test_reset();
        test_default_frame();
        test_parity();
        test_back_to_back();
        test_reset_mid_frame();
        test_busy_ignore();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete within time limit");
        $fatal(1, "timeout");
    end

endmodule : tb_uart_tx_frame
`default_nettype wire
